uart_word_tx: RTL

//  UART transmitter that drives the CPU's rx line from the bench or host side of the program-upload link.
//  It accepts 32-bit words over a valid/ready handshake and serializes each word as 4 bytes.

---
 rtl/uart_word_tx.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/uart_word_tx.sv
// Word-to-UART transmitter: 32-bit words out as four 8N1 frames, MSB byte first.
// Optional even-parity bit per frame when UART_TX_PARITY_EN is defined.
module uart_word_tx #(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 128_000
) (
    input  logic        clk,
    input  logic        fpga_rst,
    input  logic        word_valid,
    input  logic [31:0] word_data,
    output logic        word_ready,
    output logic        tx,
    output logic        busy,
    output logic        word_done
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP
    } state_t;
`endif

    state_t        state_q, state_n;
    logic [CW-1:0] baud_q, baud_n;
    logic [2:0]    bit_q, bit_n;
    logic [1:0]    byte_q, byte_n;
    logic [31:0]   shreg_q, shreg_n;
    logic          tx_q, tx_n;
    logic [7:0]    cur_byte;
    logic          bit_end;
    logic          accept;

    assign tx = tx_q;

    // Next-state, counters and the next line level.
    always_comb begin
        state_n  = state_q;
        bit_n    = bit_q;
        byte_n   = byte_q;
        shreg_n  = shreg_q;
        tx_n     = tx_q;
        cur_byte = shreg_q[31:24];
        bit_end  = (baud_q == LAST);

        word_done  = (state_q == STOP) && (byte_q == 2'd3)
                     && bit_end;
        word_ready = (state_q == IDLE) || word_done;
        busy       = !word_ready;
        accept     = word_valid && word_ready;

        if (state_q == IDLE || bit_end) baud_n = '0;
        else                            baud_n = baud_q + 1'b1;

        unique case (state_q)
            IDLE: tx_n = 1'b1;
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    bit_n   = 3'd0;
                    tx_n    = cur_byte[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
                        tx_n    = ^cur_byte;
`else
                        state_n = STOP;
                        tx_n    = 1'b1;
`endif
                    end else begin
                        bit_n = bit_q + 3'd1;
                        tx_n  = cur_byte[bit_q + 3'd1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_n = STOP;
                    tx_n    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (byte_q == 2'd3) begin
                        state_n = IDLE;
                        byte_n  = 2'd0;
                        tx_n    = 1'b1;
                    end else begin
                        state_n = START;
                        byte_n  = byte_q + 2'd1;
                        shreg_n = {shreg_q[23:0], 8'h00};
                        tx_n    = 1'b0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase

        // A new word can start in the word_done cycle with no gap.
        if (accept) begin
            state_n = START;
            shreg_n = word_data;
            baud_n  = '0;
            bit_n   = 3'd0;
            byte_n  = 2'd0;
            tx_n    = 1'b0;
        end
    end

    // State, counters, shift register and registered tx.
    always_ff @(posedge clk) begin
        if (fpga_rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            byte_q  <= 2'd0;
            shreg_q <= 32'h0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_n;
            baud_q  <= baud_n;
            bit_q   <= bit_n;
            byte_q  <= byte_n;
            shreg_q <= shreg_n;
            tx_q    <= tx_n;
        end
    end

endmodule
